// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the loadable instruction memory.
//   - imem_state_e : loader FSM states (S_EMPTY, S_LOAD, S_READY)
//   - IMEM_DATA_W / IMEM_ADDR_W / IMEM_DEPTH : default geometry
//   - IMEM_NOP     : all-zero instruction returned for out-of-range fetches
//   - imem_parity  : even-parity bit of a word (zero-extend narrower words)
package imem_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } imem_state_e;

  localparam int IMEM_DATA_W = 10;
  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DEPTH  = 1024;

  localparam logic [63:0] IMEM_NOP = '0;

  // Zero-extension leaves the XOR reduction unchanged, so one 64-bit
  // function serves every DATA_W up to 64.
  function automatic logic imem_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: 1-write/1-read RAM with synchronous (registered) read.
//   clk   : rising-edge clock
//   we    : write enable; wdata written to mem[waddr]
//   re    : read enable; rdata <= mem[raddr], otherwise rdata holds
//   W     : word width, DEPTH : number of words, IW : address width
// No reset on the storage or the read register; the top masks rdata
// until a valid fetch has completed.
module imem_array #(
  parameter int W     = 10,
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loadable instruction memory between the boot/debug
// loader and the core fetch stage.
//   Load port  : load_valid/load_ready handshake, load_data, load_last;
//                words are written sequentially from address 0.
//   Control    : reload (pulse) discards the program and re-arms loading.
//   Fetch port : fetch_en/fetch_addr in; fetch_data/fetch_valid one cycle
//                later; only honoured once a program is loaded.
//   Status     : prog_ready, load_count, sticky load_ovf/oob_err/parity_err.
//   inj_par_err: inverts the stored parity bit of the current beat.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity check).
// Reset: synchronous, active-low rst_n.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              prog_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  output logic              oob_err,
  input  logic              inj_par_err,
  output logic              parity_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  imem_state_e       state, state_n;
  logic [IW-1:0]     wptr;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q, oob_q, par_q;
  logic              fv_q;
  logic              zero_sel;   // 1: present NOP instead of RAM output
  logic              beat, at_end, last_eff;
  logic              fetch_go, in_range, par_hit;
  logic [MW-1:0]     wdata, rdata;

  // reload takes priority over any beat or fetch in the same cycle
  assign beat     = load_valid && load_ready && !reload;
  assign at_end   = (wptr == IW'(DEPTH - 1));
  assign last_eff = load_last || at_end;
  assign fetch_go = (state == S_READY) && fetch_en && !reload;
  assign in_range = ({1'b0, fetch_addr} < count_q);

  always_comb begin
    state_n    = state;
    load_ready = 1'b0;
    prog_ready = 1'b0;
    case (state)
      S_EMPTY, S_LOAD: begin
        load_ready = 1'b1;
        if (beat) state_n = last_eff ? S_READY : S_LOAD;
      end
      S_READY: prog_ready = 1'b1;
      default: state_n = S_EMPTY;
    endcase
    if (reload) state_n = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      oob_q    <= 1'b0;
      par_q    <= 1'b0;
      fv_q     <= 1'b0;
      zero_sel <= 1'b1;
    end else begin
      fv_q <= fetch_go;
      if (fetch_go) zero_sel <= !in_range;
      if (reload) begin
        wptr    <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        oob_q   <= 1'b0;
        par_q   <= 1'b0;
      end else begin
        if (beat) begin
          if (!at_end) wptr <= wptr + IW'(1);
          count_q <= count_q + (ADDR_W + 1)'(1);
          if (at_end && !load_last) ovf_q <= 1'b1;
        end
        if (fetch_go && !in_range) oob_q <= 1'b1;
        if (par_hit) par_q <= 1'b1;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata   = {imem_parity(64'(load_data)) ^ inj_par_err, load_data};
  assign par_hit = fv_q && !zero_sel &&
                   (rdata[DATA_W] != imem_parity(64'(rdata[DATA_W-1:0])));
`else
  logic unused_inj;
  assign unused_inj = inj_par_err;
  assign wdata      = load_data;
  assign par_hit    = 1'b0;
`endif

  imem_array #(
    .W     (MW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (beat),
    .waddr (wptr),
    .wdata (wdata),
    .re    (fetch_go && in_range),
    .raddr (fetch_addr[IW-1:0]),
    .rdata (rdata)
  );

  assign fetch_data  = zero_sel ? DATA_W'(IMEM_NOP) : rdata[DATA_W-1:0];
  assign fetch_valid = fv_q;
  assign load_count  = count_q;
  assign load_ovf    = ovf_q;
  assign oob_err     = oob_q;
  // mismatch is flagged alongside fetch_valid, then held by par_q
  assign parity_err  = par_q || par_hit;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: self-checking bench for instr_mem_loader.
// Expected fetch words are queued when a fetch is issued and compared
// when fetch_valid appears. A second instance with DEPTH=8 covers the
// overflow path. Inputs are driven on the falling edge, outputs sampled
// on the falling edge.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid, load_last, reload, fetch_en, inj;
  logic [9:0] load_data, fetch_addr;
  logic       load_ready, fetch_valid, prog_ready, load_ovf, oob_err, parity_err;
  logic [9:0] fetch_data;
  logic [10:0] load_count;

  logic       e_load_valid, e_load_last, e_reload, e_fetch_en;
  logic [9:0] e_load_data, e_fetch_addr;
  logic       e_load_ready, e_fetch_valid, e_prog_ready, e_load_ovf, e_oob_err, e_parity_err;
  logic [9:0] e_fetch_data;
  logic [10:0] e_load_count;

  int checks = 0;
  int failures = 0;
  int fv_count = 0;
  logic [9:0] sb[$];
  logic [9:0] prog [8];
  logic       exp_par;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .reload(reload),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .prog_ready(prog_ready), .load_count(load_count),
    .load_ovf(load_ovf), .oob_err(oob_err), .inj_par_err(inj), .parity_err(parity_err)
  );

  instr_mem_loader #(.DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .load_valid(e_load_valid), .load_ready(e_load_ready),
    .load_data(e_load_data), .load_last(e_load_last), .reload(e_reload),
    .fetch_en(e_fetch_en), .fetch_addr(e_fetch_addr), .fetch_data(e_fetch_data),
    .fetch_valid(e_fetch_valid), .prog_ready(e_prog_ready), .load_count(e_load_count),
    .load_ovf(e_load_ovf), .oob_err(e_oob_err), .inj_par_err(1'b0),
    .parity_err(e_parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (fetch_valid) begin
      fv_count++;
      if (sb.size() == 0) chk("fv_unexpected", 1, 0);
      else chk("fetch_data", fetch_data, sb.pop_front());
    end
  end

  task automatic load_prog(input int n, input bit thr, input int inj_idx);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == n - 1);
      inj        = (i == inj_idx);
      if (!thr && n > 1 && i == n - 1) chk("pre_ready", prog_ready, 0);
      @(negedge clk);
      if (thr) begin
        load_valid = 1'b0;
        load_data  = 10'h3C3;
        load_last  = 1'b1;
        inj        = 1'b0;
        @(negedge clk);
        chk("thr_count", load_count, i + 1);
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    inj        = 1'b0;
  endtask

  task automatic fetch_burst(input int n);
    fv_count = 0;
    for (int i = 0; i < n; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 10'(i);
      sb.push_back(prog[i]);
      @(negedge clk);
    end
    fetch_en = 1'b0;
    @(negedge clk);
    chk("burst_fv_count", fv_count, n);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef IMEM_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    rst_n = 1'b0;
    {load_valid, load_last, reload, fetch_en, inj} = '0;
    load_data = '0; fetch_addr = '0;
    {e_load_valid, e_load_last, e_reload, e_fetch_en} = '0;
    e_load_data = '0; e_fetch_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_flags", {load_ovf, oob_err, parity_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic 4-word program
    prog[0] = 10'h001; prog[1] = 10'h350; prog[2] = 10'h359; prog[3] = 10'h082;
    load_prog(4, 1'b0, -1);
    chk("ld_prog_ready", prog_ready, 1);
    chk("ld_count", load_count, 4);
    chk("ld_ready_low", load_ready, 0);
    chk("ld_ovf", load_ovf, 0);
    fetch_burst(4);
    chk("hold_fetch_data", fetch_data, 10'h082);
    chk("no_oob", oob_err, 0);

    // out-of-range fetch
    fetch_en = 1'b1; fetch_addr = 10'd7; sb.push_back(10'h000);
    @(negedge clk);
    fetch_en = 1'b0;
    chk("oob_fv", fetch_valid, 1);
    chk("oob_set", oob_err, 1);
    @(negedge clk);
    chk("oob_sticky", oob_err, 1);

    // reload and fetch in the same cycle: reload wins
    reload = 1'b1; fetch_en = 1'b1; fetch_addr = 10'd0;
    @(negedge clk);
    reload = 1'b0; fetch_en = 1'b0;
    chk("rl_fv", fetch_valid, 0);
    chk("rl_prog_ready", prog_ready, 0);
    chk("rl_count", load_count, 0);
    chk("rl_flags", {load_ovf, oob_err, parity_err}, 0);
    chk("rl_load_ready", load_ready, 1);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("empty_fetch_ignored", fetch_valid, 0);

    // throttled loader, new program
    prog[0] = 10'h2AA; prog[1] = 10'h155; prog[2] = 10'h3FF; prog[3] = 10'h010;
    prog[4] = 10'h123;
    load_prog(5, 1'b1, -1);
    chk("thr_prog_ready", prog_ready, 1);
    fetch_burst(5);

    // parity injection on word 2
    pulse_reload();
    prog[0] = 10'h0F0; prog[1] = 10'h00F; prog[2] = 10'h1A5; prog[3] = 10'h3C0;
    load_prog(4, 1'b0, 2);
    chk("par_before", parity_err, 0);
    fetch_en = 1'b1; fetch_addr = 10'd2; sb.push_back(10'h1A5);
    @(negedge clk);
    fetch_en = 1'b0;
    chk("par_flag", parity_err, {31'd0, exp_par});
    @(negedge clk);
    chk("par_sticky", parity_err, {31'd0, exp_par});
    fetch_burst(4);

    // DEPTH=8 overflow
    for (int i = 0; i < 8; i++) begin
      e_load_valid = 1'b1;
      e_load_data  = 10'(i * 3 + 1);
      if (i == 7) chk("e_ovf_pre", e_load_ovf, 0);
      @(negedge clk);
    end
    chk("e_prog_ready", e_prog_ready, 1);
    chk("e_ovf", e_load_ovf, 1);
    chk("e_load_ready", e_load_ready, 0);
    chk("e_count", e_load_count, 8);
    e_load_data = 10'h3FF;
    @(negedge clk);
    e_load_valid = 1'b0;
    chk("e_ninth_refused", e_load_count, 8);
    e_fetch_en = 1'b1; e_fetch_addr = 10'd7;
    @(negedge clk);
    e_fetch_en = 1'b0;
    chk("e_fv", e_fetch_valid, 1);
    chk("e_last_word", e_fetch_data, 10'd22);
    chk("e_no_oob", {e_oob_err, e_parity_err}, 0);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, loadable instruction memory that succeeds the team's fixed 10-bit combinational program ROM. A program is streamed in over a valid/ready load port and written sequentially from address 0. Once loading completes, the core fetches over a registered fetch port with one-cycle latency. It sits between the boot/debug loader and the single-cycle core's PC/fetch stage.

## Interface
- DATA_W, 10, instruction word width in bits.
- ADDR_W, 10, fetch/load address width in bits.
- DEPTH, 1024, number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- load_valid  in  1  loader presents a word.
- load_ready  out  1  block accepts a word.
- load_data  in  DATA_W  instruction word.
- load_last  in  1  marks the final word of the program.
- reload  in  1  single-cycle pulse; discards the current program and re-arms loading.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address (the PC).
- fetch_data  out  DATA_W  registered instruction.
- fetch_valid  out  1  fetch_data is valid this cycle.
- prog_ready  out  1  a program is loaded and fetch is enabled.
- load_count  out  ADDR_W+1  number of words loaded.
- load_ovf  out  1  sticky; set when a DEPTH-th word arrives without load_last.
- oob_err  out  1  sticky; set on a fetch at address ≥ load_count.
- inj_par_err  in  1  parity fault injection; used only with the parity macro.
- parity_err  out  1  sticky parity mismatch flag.

## Operation
- FSM states are S_EMPTY, S_LOAD and S_READY. Reset enters S_EMPTY.
- load_ready is 1 in S_EMPTY and S_LOAD, and 0 in S_READY.
- A beat transfers when load_valid && load_ready. Each beat writes load_data to mem[wptr], then increments wptr and load_count.
- S_EMPTY → S_LOAD on the first beat without load_last. S_EMPTY → S_READY on a first beat that carries load_last.
- S_LOAD → S_READY on a beat with load_last.
- A beat at wptr = DEPTH-1 is forced to act as last. If load_last was low on that beat, load_ovf sets.
- S_READY → S_EMPTY on reload. Reload also clears wptr, load_count, load_ovf, oob_err and parity_err. reload in S_EMPTY or S_LOAD restarts the load identically.
- Fetch is honoured only in S_READY. For fetch_addr < load_count, fetch_data = mem[fetch_addr].
- For fetch_addr ≥ load_count, fetch_data = 0 (NOP) and oob_err sets.
- fetch_en outside S_READY is ignored: fetch_valid stays 0 and fetch_data holds its value.
- If reload and fetch_en occur in the same cycle, reload wins and the fetch is dropped.
- Memory contents are not cleared by reset or reload. They remain unreadable until rewritten, because of the load_count bound.

## Timing
- Reset values:
  - State: S_EMPTY.
  - Outputs: load_ready = 1, fetch_data = 0, fetch_valid = 0, prog_ready = 0, load_count = 0, load_ovf = 0, oob_err = 0, parity_err = 0.
- Load throughput is one word per cycle while load_valid is held.
- prog_ready rises on the cycle after the last beat.
- Fetch latency is 1 cycle: with fetch_en at edge N, fetch_data and fetch_valid appear after edge N. Back-to-back fetches give one result per cycle.
- A write followed by a fetch of the same address in the next cycle is impossible, because fetch is only allowed in S_READY.
- Reset mid-load or mid-fetch takes effect at the next edge. No partial beat is retained.

## Configuration
- IMEM_PARITY_EN defined:
  - Each stored word carries an extra even-parity bit computed at load time.
  - inj_par_err high during a beat inverts the stored parity bit.
  - On a fetch, a parity mismatch sets parity_err in the same cycle as fetch_valid. The data is still delivered.
- IMEM_PARITY_EN undefined:
  - Storage is DATA_W wide.
  - inj_par_err is ignored.
  - parity_err is constant 0.

## Structure
- Package imem_pkg holds:
  - the state enum (S_EMPTY, S_LOAD, S_READY);
  - default DATA_W, ADDR_W and DEPTH constants;
  - the NOP constant (all zeros);
  - a parity function.
- Sub-module imem_array: a 1-write/1-read synchronous-read RAM of width DATA_W (+1 with parity) and depth DEPTH.
- The FSM, counters and error flags live in the top level.

## Test plan
- Reset, then stream 4 words (0x001, 0x350, 0x359, 0x082; last on the 4th) → prog_ready = 1 one cycle later, load_count = 4. Fetch addresses 0–3 back-to-back → the same words return with 1-cycle latency, fetch_valid high for 4 cycles.
- Fetch address 7 after a 4-word load → fetch_data = 0, fetch_valid = 1, oob_err = 1 and stays set.
- Loader throttled with load_valid toggling every cycle → only asserted cycles write, load_count increments once per beat, and the contents verify on readback.
- DEPTH = 8 build, 8 words streamed with no last → S_READY after the 8th beat, load_ovf = 1, load_ready = 0. A 9th valid is not accepted.
- reload and fetch_en in the same cycle in S_READY → no fetch_valid, state S_EMPTY, load_count = 0, flags cleared. A subsequent new program reads back correctly.
- With IMEM_PARITY_EN: word 2 loaded with inj_par_err = 1 → fetch address 2 gives the correct data and parity_err = 1. Without the macro, parity_err = 0 throughout.
